// File: rtl/qei_encoder_emulator_if.sv
// Command/status bundle for the quadrature encoder emulator.
// The bench (or host logic) drives the master side; the emulator is the slave.
interface qei_encoder_emulator_if #(
  parameter int VEL_W = 32,
  parameter int POS_W = 32
);
  logic                    en;
  logic signed [VEL_W-1:0] vel;
  logic                    pos_load;
  logic [POS_W-1:0]        pos_load_val;
  logic                    ovr_clr;
  logic                    enc_a;
  logic                    enc_b;
  logic                    enc_z;
  logic signed [POS_W-1:0] pos;
  logic                    step_strobe;
  logic                    overrun;

  modport master (
    output en, vel, pos_load, pos_load_val, ovr_clr,
    input  enc_a, enc_b, enc_z, pos, step_strobe, overrun
  );

  modport slave (
    input  en, vel, pos_load, pos_load_val, ovr_clr,
    output enc_a, enc_b, enc_z, pos, step_strobe, overrun
  );
endinterface

// File: rtl/qei_encoder_emulator.sv
// Quadrature encoder transmitter: turns a signed velocity command into A/B/Z
// edges through a fractional NCO, a minimum-edge-gap limiter with a one-deep
// pending buffer, and a wrapping position counter.
// The bus interface instance must be built with the same VEL_W/POS_W.
module qei_encoder_emulator #(
  parameter int ACC_W   = 32,
  parameter int VEL_W   = 32,
  parameter int POS_W   = 32,
  parameter int CPR     = 2048,
  parameter int MIN_GAP = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  qei_encoder_emulator_if.slave  bus
);

  localparam int IDX_W = (CPR > 1) ? $clog2(CPR) : 1;
  localparam int GAP_W = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(CPR - 1);
  localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(MIN_GAP - 1);
  localparam logic [VEL_W-1:0] VEL_MIN    = {1'b1, {(VEL_W-1){1'b0}}};
  localparam logic [VEL_W-1:0] VEL_MAX    = {1'b0, {(VEL_W-1){1'b1}}};

  // State registers
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [1:0]       ph_q, ph_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             pend_q, pend_d;
  logic             pend_dir_q, pend_dir_d;   // 1 = forward
  logic [POS_W-1:0] pos_q, pos_d;
  logic             enc_a_q, enc_a_d;
  logic             enc_b_q, enc_b_d;
  logic             enc_z_q, enc_z_d;
  logic             strobe_q, strobe_d;
  logic             ovr_q, ovr_d;

  // Combinational helpers
  logic [VEL_W-1:0] vel_mag_s;
  logic [ACC_W:0]   mag_ext_s;
  logic [ACC_W:0]   sum_s;
  logic             req_s;
  logic             req_dir_s;
  logic             issue_s;
  logic             issue_dir_s;
  logic             ovr_evt_s;

  // Magnitude of the velocity command; the most negative value saturates
  always_comb begin
    vel_mag_s = bus.vel;
    if (bus.vel[VEL_W-1]) begin
      if (bus.vel == VEL_MIN) begin
        vel_mag_s = VEL_MAX;
      end else begin
        vel_mag_s = -bus.vel;
      end
    end else begin
      vel_mag_s = bus.vel;
    end
  end

  // Next-state logic: NCO, limiter/pending buffer, phase/index/position, outputs
  always_comb begin
    mag_ext_s              = '0;
    mag_ext_s[VEL_W-1:0]   = vel_mag_s;
    sum_s                  = {1'b0, acc_q} + mag_ext_s;
    req_dir_s              = ~bus.vel[VEL_W-1];
    acc_d       = acc_q;
    ph_d        = ph_q;
    idx_d       = idx_q;
    gap_d       = gap_q;
    pend_d      = pend_q;
    pend_dir_d  = pend_dir_q;
    pos_d       = pos_q;
    ovr_d       = ovr_q;
    req_s       = 1'b0;
    issue_s     = 1'b0;
    issue_dir_s = 1'b1;
    ovr_evt_s   = 1'b0;

    // NCO: a carry out of the accumulator is a step request
    if (bus.en) begin
      acc_d = sum_s[ACC_W-1:0];
      req_s = sum_s[ACC_W];
    end else begin
      acc_d = '0;
      req_s = 1'b0;
    end

    // Limiter and pending buffer; a buffered step is served before a fresh one
    if (!bus.en) begin
      pend_d = 1'b0;
    end else if ((req_s || pend_q) && (gap_q == '0)) begin
      issue_s     = 1'b1;
      issue_dir_s = pend_q ? pend_dir_q : req_dir_s;
      pend_d      = pend_q & req_s;
      pend_dir_d  = req_dir_s;
    end else if (req_s) begin
      if (pend_q) begin
        ovr_evt_s = 1'b1;
      end else begin
        pend_d     = 1'b1;
        pend_dir_d = req_dir_s;
      end
    end else begin
      pend_d = pend_q;
    end

    // Edge-gap counter keeps running even while disabled
    if (issue_s) begin
      gap_d = GAP_RELOAD;
    end else if (gap_q != '0) begin
      gap_d = gap_q - 1'b1;
    end else begin
      gap_d = gap_q;
    end

    // Quadrature phase and index position within the revolution
    if (issue_s) begin
      if (issue_dir_s) begin
        ph_d  = ph_q + 2'd1;
        idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end else begin
        ph_d  = ph_q - 2'd1;
        idx_d = (idx_q == '0) ? IDX_LAST : idx_q - 1'b1;
      end
    end else begin
      ph_d  = ph_q;
      idx_d = idx_q;
    end

    // Position counter: a preset overrides the step for pos only
    if (bus.pos_load) begin
      pos_d = bus.pos_load_val;
    end else if (issue_s) begin
      pos_d = issue_dir_s ? pos_q + 1'b1 : pos_q - 1'b1;
    end else begin
      pos_d = pos_q;
    end

    // Sticky overrun: a new loss beats a clear on the same clock
    if (ovr_evt_s) begin
      ovr_d = 1'b1;
    end else if (bus.ovr_clr) begin
      ovr_d = 1'b0;
    end else begin
      ovr_d = ovr_q;
    end

    // Gray-coded A/B from the phase, index pulse from idx
    enc_a_d  = ph_d[1] ^ ph_d[0];
    enc_b_d  = ph_d[1];
    enc_z_d  = (idx_d == '0);
    strobe_d = issue_s;
  end

  // State update with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q      <= '0;
      ph_q       <= 2'd0;
      idx_q      <= '0;
      gap_q      <= '0;
      pend_q     <= 1'b0;
      pend_dir_q <= 1'b0;
      pos_q      <= '0;
      enc_a_q    <= 1'b0;
      enc_b_q    <= 1'b0;
      enc_z_q    <= 1'b1;
      strobe_q   <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      ph_q       <= ph_d;
      idx_q      <= idx_d;
      gap_q      <= gap_d;
      pend_q     <= pend_d;
      pend_dir_q <= pend_dir_d;
      pos_q      <= pos_d;
      enc_a_q    <= enc_a_d;
      enc_b_q    <= enc_b_d;
      enc_z_q    <= enc_z_d;
      strobe_q   <= strobe_d;
      ovr_q      <= ovr_d;
    end
  end

  assign bus.enc_a       = enc_a_q;
  assign bus.enc_b       = enc_b_q;
  assign bus.enc_z       = enc_z_q;
  assign bus.pos         = pos_q;
  assign bus.step_strobe = strobe_q;
  assign bus.overrun     = ovr_q;

endmodule
